// File: rtl/hamming_sec_decoder.sv
// Two-stage valid/ready single-error-correcting decoder: 38-bit Hamming codeword in, 32-bit data out.
// Defining HAMDEC_ERR_LOG_EN adds a sticky first-error syndrome log (err_log_valid/err_log_syn/err_log_clr).
module hamming_sec_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [37:0]      code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      data_out,
  output logic             err_corrected,
  output logic             err_uncorr,
  output logic [5:0]       syndrome_out,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
`ifdef HAMDEC_ERR_LOG_EN
  ,
  output logic             err_log_valid,
  output logic [5:0]       err_log_syn,
  input  logic             err_log_clr
`endif
);

  logic [5:0]       syn_term [38];
  logic [5:0]       syn_next;
  logic             s1_valid_reg;
  logic [37:0]      s1_code_reg;
  logic [5:0]       s1_syn_reg;
  logic [37:0]      flip_mask;
  logic [37:0]      corr_code;
  logic [31:0]      data_next;
  logic             corr_next;
  logic             uncorr_next;
  logic             out_valid_reg;
  logic [31:0]      data_out_reg;
  logic             err_corr_reg;
  logic             err_uncorr_reg;
  logic [5:0]       syndrome_reg;
  logic [CNT_W-1:0] corr_cnt_reg;
  logic [CNT_W-1:0] corr_cnt_next;
  logic [CNT_W-1:0] uncorr_cnt_reg;
  logic [CNT_W-1:0] uncorr_cnt_next;
  logic             adv2;
  logic             accept;
  logic             deliver;

  // Each set bit contributes its own Hamming position; the XOR of all of them is the syndrome.
  genvar gi;
  generate
    for (gi = 0; gi < 38; gi++) begin : g_syn
      assign syn_term[gi]  = code_in[gi] ? 6'(gi + 1) : 6'd0;
      assign flip_mask[gi] = (s1_syn_reg == 6'(gi + 1));
    end
  endgenerate

  always_comb begin
    syn_next = 6'd0;
    for (int i = 0; i < 38; i++) begin
      syn_next = syn_next ^ syn_term[i];
    end
  end

  assign adv2    = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || adv2;
  assign accept  = in_valid && in_ready;
  assign deliver = out_valid_reg && out_ready;

  // Syndromes 39..63 match no mask bit, so the word passes through untouched.
  assign corr_code   = s1_code_reg ^ flip_mask;
  assign corr_next   = (s1_syn_reg != 6'd0) && (s1_syn_reg <= 6'd38);
  assign uncorr_next = (s1_syn_reg > 6'd38);
  assign data_next   = {corr_code[37:32], corr_code[30:16], corr_code[14:8],
                        corr_code[6:4], corr_code[2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_code_reg    <= '0;
      s1_syn_reg     <= '0;
      out_valid_reg  <= 1'b0;
      data_out_reg   <= '0;
      err_corr_reg   <= 1'b0;
      err_uncorr_reg <= 1'b0;
      syndrome_reg   <= '0;
    end else begin
      if (accept) begin
        s1_code_reg <= code_in;
        s1_syn_reg  <= syn_next;
      end
      s1_valid_reg <= accept || (s1_valid_reg && !adv2);
      if (adv2) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          data_out_reg   <= data_next;
          err_corr_reg   <= corr_next;
          err_uncorr_reg <= uncorr_next;
          syndrome_reg   <= s1_syn_reg;
        end
      end
    end
  end

  // Saturating event counters; a clear beats a same-cycle increment.
  always_comb begin
    corr_cnt_next   = corr_cnt_reg;
    uncorr_cnt_next = uncorr_cnt_reg;
    if (cnt_clr) begin
      corr_cnt_next   = '0;
      uncorr_cnt_next = '0;
    end else if (deliver) begin
      if (err_corr_reg && !(&corr_cnt_reg)) begin
        corr_cnt_next = corr_cnt_reg + CNT_W'(1);
      end
      if (err_uncorr_reg && !(&uncorr_cnt_reg)) begin
        uncorr_cnt_next = uncorr_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
    end else begin
      corr_cnt_reg   <= corr_cnt_next;
      uncorr_cnt_reg <= uncorr_cnt_next;
    end
  end

`ifdef HAMDEC_ERR_LOG_EN
  logic       log_valid_reg;
  logic [5:0] log_syn_reg;
  logic       log_capture;

  // A clear arriving with a new error leaves that error as the captured one.
  assign log_capture = deliver && (err_corr_reg || err_uncorr_reg) &&
                       (!log_valid_reg || err_log_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid_reg <= 1'b0;
      log_syn_reg   <= '0;
    end else if (log_capture) begin
      log_valid_reg <= 1'b1;
      log_syn_reg   <= syndrome_reg;
    end else if (err_log_clr) begin
      log_valid_reg <= 1'b0;
      log_syn_reg   <= '0;
    end
  end

  assign err_log_valid = log_valid_reg;
  assign err_log_syn   = log_syn_reg;
`endif

  assign out_valid     = out_valid_reg;
  assign data_out      = data_out_reg;
  assign err_corrected = err_corr_reg;
  assign err_uncorr    = err_uncorr_reg;
  assign syndrome_out  = syndrome_reg;
  assign corr_cnt      = corr_cnt_reg;
  assign uncorr_cnt    = uncorr_cnt_reg;

endmodule

// File: tb/tb_hamming_sec_decoder.sv
// Directed self-checking bench for hamming_sec_decoder (narrow counters so saturation is reachable).
module tb_hamming_sec_decoder;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [37:0]   code_in;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   data_out;
  logic          err_corrected;
  logic          err_uncorr;
  logic [5:0]    syndrome_out;
  logic          cnt_clr;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;
`ifdef HAMDEC_ERR_LOG_EN
  logic          err_log_valid;
  logic [5:0]    err_log_syn;
  logic          err_log_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hamming_sec_decoder #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .code_in      (code_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .err_corrected(err_corrected),
    .err_uncorr   (err_uncorr),
    .syndrome_out (syndrome_out),
    .cnt_clr      (cnt_clr),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt)
`ifdef HAMDEC_ERR_LOG_EN
    ,
    .err_log_valid(err_log_valid),
    .err_log_syn  (err_log_syn),
    .err_log_clr  (err_log_clr)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: place data, then set each parity bit so the syndrome becomes zero.
  function automatic logic [37:0] encode(input logic [31:0] d);
    logic [37:0] c;
    logic [5:0]  s;
    c          = '0;
    c[2]       = d[0];
    c[6:4]     = d[3:1];
    c[14:8]    = d[10:4];
    c[30:16]   = d[25:11];
    c[37:32]   = d[31:26];
    s          = '0;
    for (int i = 0; i < 38; i++) begin
      if (c[i]) s = s ^ 6'(i + 1);
    end
    c[0]  = s[0];
    c[1]  = s[1];
    c[3]  = s[2];
    c[7]  = s[3];
    c[15] = s[4];
    c[31] = s[5];
    return c;
  endfunction

  // Single word: accept, confirm empty output after one edge, check the word after the second.
  task automatic send_and_check(input string tag, input logic [37:0] cw, input logic [31:0] ed,
                                input logic [5:0] es, input logic ec, input logic eu);
    in_valid  = 1'b1;
    code_in   = cw;
    out_ready = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    code_in  = '0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(data_out), 64'(ed));
    check({tag, "_syn"}, 64'(syndrome_out), 64'(es));
    check({tag, "_corr"}, 64'(err_corrected), 64'(ec));
    check({tag, "_uncorr"}, 64'(err_uncorr), 64'(eu));
  endtask

  logic [31:0] sd  [8];
  logic [37:0] scw [8];
  logic [15:0] pat = 16'b1010_0110_1000_1011;
  int          sent, got, cyc, occ;
  logic        s1_full, exp_rdy, acc, saw_stall;
  logic [37:0] sat_cw;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    code_in   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
`ifdef HAMDEC_ERR_LOG_EN
    err_log_clr = 1'b0;
`endif
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_syn", 64'(syndrome_out), 64'd0);
    check("rst_flags", 64'({err_corrected, err_uncorr}), 64'd0);
    check("rst_corr_cnt", 64'(corr_cnt), 64'd0);
    check("rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

    send_and_check("zero", 38'd0, 32'h0000_0000, 6'd0, 1'b0, 1'b0);
    tick();
    check("zero_corr_cnt", 64'(corr_cnt), 64'd0);
    check("zero_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

    send_and_check("bit37", 38'h20_0000_0000, 32'h0000_0000, 6'd38, 1'b1, 1'b0);
    tick();
    check("bit37_corr_cnt", 64'(corr_cnt), 64'd1);

    send_and_check("dbl", (38'd1 << 31) | (38'd1 << 6), 32'h0000_0008, 6'd39, 1'b0, 1'b1);
    tick();
    check("dbl_uncorr_cnt", 64'(uncorr_cnt), 64'd1);
    check("dbl_corr_cnt", 64'(corr_cnt), 64'd1);
`ifdef HAMDEC_ERR_LOG_EN
    check("log_valid", 64'(err_log_valid), 64'd1);
    check("log_syn_sticky", 64'(err_log_syn), 64'd38);
`endif

    send_and_check("deadbeef", encode(32'hDEAD_BEEF) ^ (38'd1 << 9), 32'hDEAD_BEEF, 6'd10, 1'b1, 1'b0);
    tick();
    check("deadbeef_corr_cnt", 64'(corr_cnt), 64'd2);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_corr_cnt", 64'(corr_cnt), 64'd0);
    check("clr_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

    // Back-to-back stream with a fixed out_ready pattern that forces a full-pipeline stall.
    for (int k = 0; k < 8; k++) begin
      sd[k]  = $urandom;
      scw[k] = encode(sd[k]) ^ (38'd1 << $urandom_range(0, 37));
    end
    sent = 0;
    got = 0;
    cyc = 0;
    saw_stall = 1'b0;
    while (got < 8 && cyc < 200) begin
      out_ready = pat[cyc[3:0]];
      in_valid  = (sent < 8);
      code_in   = (sent < 8) ? scw[sent] : 38'd0;
      #1;
      occ     = sent - got;
      s1_full = ((occ - int'(out_valid)) == 1);
      exp_rdy = !(s1_full && out_valid && !out_ready);
      check("stream_in_ready", 64'(in_ready), 64'(exp_rdy));
      if (!in_ready) saw_stall = 1'b1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check($sformatf("stream_data%0d", got), 64'(data_out), 64'(sd[got]));
        check("stream_corr", 64'(err_corrected), 64'd1);
        got++;
      end
      if (acc) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    code_in   = '0;
    out_ready = 1'b1;
    check("stream_all_delivered", 64'(got), 64'd8);
    check("stream_saw_stall", 64'(saw_stall), 64'd1);
    tick();
    check("stream_corr_cnt", 64'(corr_cnt), 64'd8);
    check("stream_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

    send_and_check("clrhs", encode(32'h1234_5678) ^ (38'd1 << 20), 32'h1234_5678, 6'd21, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    check("clrhs_pre_cnt", 64'(corr_cnt), 64'd8);
    tick();
    cnt_clr = 1'b0;
    check("clrhs_cnt", 64'(corr_cnt), 64'd0);

    sat_cw    = encode(32'hA5A5_0F0F) ^ 38'd1;
    in_valid  = 1'b1;
    code_in   = sat_cw;
    repeat (15) tick();
    in_valid  = 1'b0;
    code_in   = '0;
    repeat (3) tick();
    check("sat_reach_max", 64'(corr_cnt), 64'd15);
    send_and_check("sat", sat_cw, 32'hA5A5_0F0F, 6'd1, 1'b1, 1'b0);
    tick();
    check("sat_hold_max", 64'(corr_cnt), 64'd15);

    // Fill both stages, then reset asynchronously between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = encode(32'h1111_1111);
    tick();
    code_in   = encode(32'h2222_2222);
    tick();
    in_valid  = 1'b0;
    code_in   = '0;
    #1;
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_corr_cnt", 64'(corr_cnt), 64'd0);
`ifdef HAMDEC_ERR_LOG_EN
    check("arst_log_valid", 64'(err_log_valid), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 64'(out_valid), 64'd0);
    send_and_check("post_rst", encode(32'hCAFE_F00D), 32'hCAFE_F00D, 6'd0, 1'b0, 1'b0);
    tick();
    check("post_rst_no_stale", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_sec_decoder.md
Name: hamming_sec_decoder

Overview:
- Receive-side companion to the team's 32-bit Hamming encoder.
- Takes a 38-bit single-error-correcting codeword, computes the 6-bit syndrome, corrects any single-bit error, and delivers the 32-bit data word with status flags.
- Two-stage valid/ready pipeline with saturating error counters; sits between the storage/link output and the data consumer.

Parameters:
CNT_W, 16, width of the corrected and uncorrectable event counters (saturating)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream codeword valid
in_ready  output  1  decoder can accept a codeword this cycle
code_in  input  38  codeword, layout below
out_valid  output  1  decoded word valid
out_ready  input  1  downstream accepts the word
data_out  output  32  corrected data
err_corrected  output  1  a single-bit error was corrected in this word
err_uncorr  output  1  syndrome is outside 1..38; data passed uncorrected
syndrome_out  output  6  raw syndrome of this word
cnt_clr  input  1  synchronous clear of both counters
corr_cnt  output  CNT_W  count of delivered words with err_corrected=1
uncorr_cnt  output  CNT_W  count of delivered words with err_uncorr=1

Behaviour:
- Reset: one clock, asynchronous active-low reset on rst_n. While rst_n=0, all registers clear: out_valid=0, data_out=0, flags=0, syndrome_out=0, counters=0, both stage-valid bits=0. Any in-flight words are discarded.
- Codeword layout: code_in[i] is Hamming position p=i+1.
  - Parity bits sit at p=1,2,4,8,16,32 (bits 0,1,3,7,15,31).
  - Data bits: D0=bit2, D[3:1]=bits[6:4], D[10:4]=bits[14:8], D[25:11]=bits[30:16], D[31:26]=bits[37:32].
- Syndrome: S[k] = XOR of code_in[i] over all i where bit k of (i+1) is 1, for k=0..5. S equals the p of a single flipped bit.
- Stage 1: on accept (in_valid && in_ready), register code_in and S, and set s1_valid.
- Stage 2: on advance, take the stage-1 contents.
  - S=0: no error.
  - S in 1..38: flip code bit S-1, err_corrected=1.
  - S in 39..63: no flip, err_uncorr=1.
  - Extract data per the layout; register data_out, flags and syndrome_out; set out_valid.
- Handshake:
  - adv2 = !out_valid || out_ready.
  - Stage 2 loads when adv2 && s1_valid. It clears out_valid when adv2 && !s1_valid.
  - in_ready = !s1_valid || adv2 (combinational from out_ready).
  - s1_valid next = accept || (s1_valid && !adv2).
- Latency: 2 cycles from accept to out_valid. Throughput 1 word/cycle when out_ready=1.
- Stall: outputs hold stable while out_valid && !out_ready. No word is dropped or duplicated.
- Double errors: this is SEC only. A double error may alias to a valid syndrome and be miscorrected, reported as err_corrected. This is accepted behaviour.
- Counters:
  - Increment only on output handshake (out_valid && out_ready) when the respective flag is set.
  - Saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 forces 0 on the next edge. If a clear coincides with an increment, the clear wins.

Optional Feature:
- Macro: HAMDEC_ERR_LOG_EN.
- Defined: adds ports err_log_valid (1, output), err_log_syn (6, output), err_log_clr (1, input).
  - On the first delivered word with err_corrected or err_uncorr, capture its syndrome and set err_log_valid.
  - Later errors do not overwrite the captured syndrome (sticky).
  - err_log_clr clears err_log_valid and err_log_syn on the next edge; if it coincides with a new capture, the capture wins.
  - Both outputs reset to 0.
- Not defined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- All-zero codeword, out_ready=1 -> after 2 cycles: data_out=0x00000000, syndrome_out=0, both flags 0, counters unchanged.
- code_in=38'h20_0000_0000 (bit 37 flipped) -> syndrome_out=38, data_out=0x00000000, err_corrected=1, corr_cnt increments by 1.
- code_in = bits 31 and 6 set -> syndrome_out=39, err_uncorr=1, data_out=0x00000008 (uncorrected), uncorr_cnt increments by 1.
- Back-to-back stream of 8 random encoded words, each with one random single-bit flip, with out_ready toggling pseudo-randomly:
  - Every word is delivered in order with the original data.
  - in_ready drops when both stages are full and out_ready=0.
  - corr_cnt=8.
- Assert cnt_clr on the same cycle as a corrected-word handshake -> corr_cnt=0 next cycle. Preload corr_cnt to 2^CNT_W-1 via repeated errors, send one more error -> corr_cnt holds at max.
- Drive rst_n low mid-stream with both stages full -> out_valid=0 and in_ready=1 immediately. After release, the first new word emerges 2 cycles after its accept, with no stale words.
